// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// FUNC_* must stay identical to the pipeline's EX-stage encoding.
package muldiv_seq_pkg;

    localparam int W_FUNC = 2;
    localparam logic [W_FUNC-1:0] FUNC_MUL = 2'd1;
    localparam logic [W_FUNC-1:0] FUNC_DIV = 2'd2;

    localparam int MD_WIDTH   = 32;
    localparam int ITER_COUNT = MD_WIDTH;
    localparam logic [MD_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the final sign correction of results.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32x32 multiply / restoring divide, one bit per cycle, with
// pipeline stall, flush and single-cycle HI/LO write strobes.
//   state | meaning
//   IDLE  | waiting for a request; stall asserted in the accept cycle
//   RUN   | one shift-add / restoring-divide iteration per cycle
//   FIX   | sign correction, result registered into write data
//   DONE  | write strobes for one cycle, stall released
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [W_FUNC-1:0] mulalu_func,
    input  logic              mulalu_sign,
    input  logic [WIDTH-1:0]  source_a,
    input  logic [WIDTH-1:0]  source_b,
    input  logic              flush,
    output logic              stall,
    output logic              hi_write,
    output logic [WIDTH-1:0]  hi_write_data,
    output logic              lo_write,
    output logic [WIDTH-1:0]  lo_write_data
);

    muldiv_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               req;
    logic               req_div;
    logic               req_div0;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] div_shift;
    logic [WIDTH:0]     div_trial;

    assign req      = ((mulalu_func == FUNC_MUL) || (mulalu_func == FUNC_DIV)) && !flush;
    assign req_div  = (mulalu_func == FUNC_DIV);
    assign req_div0 = req && req_div && (source_b == '0);

    muldiv_sign_fix #(.W(WIDTH)) u_a_abs (
        .neg_i (mulalu_sign & source_a[WIDTH-1]),
        .val_i (source_a),
        .val_o (a_mag)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_b_abs (
        .neg_i (mulalu_sign & source_b[WIDTH-1]),
        .val_i (source_b),
        .val_o (b_mag)
    );

    muldiv_sign_fix #(.W(2*WIDTH)) u_prod_fix (
        .neg_i (res_neg_q),
        .val_i (acc_q),
        .val_o (prod_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_quot_fix (
        .neg_i (res_neg_q),
        .val_i (acc_q[WIDTH-1:0]),
        .val_o (quot_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_rem_fix (
        .neg_i (rem_neg_q),
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .val_o (rem_fix)
    );

    // MUL: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // DIV: acc = {rem, quot}; the trial keeps the bit shifted out of rem.
    assign div_shift = {acc_q[2*WIDTH-2:0], 1'b0};
    assign div_trial = {acc_q[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, op_q};
    assign div_step  = div_trial[WIDTH] ? {div_shift[2*WIDTH-1:WIDTH], div_shift[WIDTH-1:1], 1'b0}
                                        : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req) state_d = req_div0 ? FIX : RUN;
                RUN:  if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        if (!flush) begin
            case (state_q)
                IDLE:    stall = req;
                RUN,
                FIX:     stall = 1'b1;
                DONE: begin
                    hi_write = 1'b1;
                    lo_write = 1'b1;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        op_d      = op_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d     = '0;
                    is_div_d  = req_div;
                    div0_d    = req_div0;
                    res_neg_d = mulalu_sign & (source_a[WIDTH-1] ^ source_b[WIDTH-1]);
                    rem_neg_d = mulalu_sign & source_a[WIDTH-1];
                    if (req_div0) begin
                        op_d  = '0;
                        acc_d = {{WIDTH{1'b0}}, source_a};
                    end else if (req_div) begin
                        op_d  = b_mag;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        op_d  = a_mag;
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = is_div_q ? div_step : mul_step;
            end
            FIX: begin
                if (!flush) begin
                    if (div0_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = DIV0_QUOT;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            op_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_write_data = hi_q;
    assign lo_write_data = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, div-by-zero, flush, reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [W_FUNC-1:0] mulalu_func;
    logic              mulalu_sign;
    logic [31:0]       source_a;
    logic [31:0]       source_b;
    logic              flush;
    logic              stall;
    logic              hi_write;
    logic [31:0]       hi_write_data;
    logic              lo_write;
    logic [31:0]       lo_write_data;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mulalu_func   (mulalu_func),
        .mulalu_sign   (mulalu_sign),
        .source_a      (source_a),
        .source_b      (source_b),
        .flush         (flush),
        .stall         (stall),
        .hi_write      (hi_write),
        .hi_write_data (hi_write_data),
        .lo_write      (lo_write),
        .lo_write_data (lo_write_data)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [W_FUNC-1:0] f, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
        mulalu_func = f;
        mulalu_sign = s;
        source_a    = a;
        source_b    = b;
    endtask

    task automatic clear_req();
        mulalu_func = '0;
        mulalu_sign = 1'b0;
        source_a    = '0;
        source_b    = '0;
    endtask

    // Called just after a posedge with the request already driven.
    task automatic finish_op(input string name, input int exp_stalls,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  stalls;
        int  cyc;
        bit  got;
        stalls = 0;
        cyc    = 0;
        got    = 0;
        @(negedge clk);
        while (!got && cyc < 80) begin
            if (hi_write || lo_write) begin
                got = 1;
            end else begin
                if (stall) stalls++;
                @(posedge clk);
                #1 clear_req();
                @(negedge clk);
                cyc++;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: no strobe after %0d cycles", name, cyc);
        end else begin
            n_checks++;
            if (stalls !== exp_stalls) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
            end
            n_checks++;
            if ({hi_write, lo_write, stall} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s done_strobes {hi_w,lo_w,stall}: got %b expected 110",
                         name, {hi_write, lo_write, stall});
            end
            n_checks++;
            if (hi_write_data !== exp_hi) begin
                n_fail++;
                $display("FAIL %s hi_data: got %08h expected %08h", name, hi_write_data, exp_hi);
            end
            n_checks++;
            if (lo_write_data !== exp_lo) begin
                n_fail++;
                $display("FAIL %s lo_data: got %08h expected %08h", name, lo_write_data, exp_lo);
            end
            @(negedge clk);
            n_checks++;
            if ({hi_write, lo_write, stall} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s after_done {hi_w,lo_w,stall}: got %b expected 000",
                         name, {hi_write, lo_write, stall});
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W_FUNC-1:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input int exp_stalls,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk);
        #1 start_op(f, s, a, b);
        finish_op(name, exp_stalls, exp_hi, exp_lo);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({stall, hi_write, lo_write, hi_write_data, lo_write_data} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b hw=%b lw=%b hi=%08h lo=%08h expected all 0",
                     stall, hi_write, lo_write, hi_write_data, lo_write_data);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_stall: got %b expected 0", stall);
        end
    endtask

    task automatic test_mul();
        run_op("umul_max", FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("smul_m3x5", FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
    endtask

    task automatic test_div();
        run_op("sdiv_m7d2", FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("udiv_100d7", FUNC_DIV, 1'b0, 32'd100, 32'd7, 34,
               32'h0000_0002, 32'h0000_000E);
        run_op("sdiv_minint", FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        run_op("udiv_by0", FUNC_DIV, 1'b0, 32'h0000_1234, 32'd0, 2,
               32'h0000_1234, 32'hFFFF_FFFF);
        run_op("sdiv_by0", FUNC_DIV, 1'b1, 32'h0000_1234, 32'd0, 2,
               32'h0000_1234, 32'hFFFF_FFFF);
        run_op("sdiv_neg_by0", FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0, 2,
               32'hFFFF_FFF9, 32'hFFFF_FFFF);
    endtask

    task automatic test_flush();
        // Flush together with a request: not accepted.
        @(posedge clk);
        #1 start_op(FUNC_MUL, 1'b0, 32'd9, 32'd9);
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_req stall: got %b expected 0", stall);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        clear_req();
        @(negedge clk);
        n_checks++;
        if ({stall, hi_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_with_req not_accepted {stall,hi_w}: got %b expected 00",
                     {stall, hi_write});
        end

        // Flush in RUN around iteration 10, then an immediate new MUL.
        @(posedge clk);
        #1 start_op(FUNC_MUL, 1'b0, 32'h1234_5678, 32'd3);
        @(posedge clk);
        #1 clear_req();
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall, hi_write, lo_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_run {stall,hi_w,lo_w}: got %b expected 000",
                     {stall, hi_write, lo_write});
        end
        @(posedge clk);
        #1 flush = 1'b0;
        start_op(FUNC_MUL, 1'b0, 32'd6, 32'd7);
        finish_op("mul_after_flush", 34, 32'd0, 32'd42);

        // Flush in DONE suppresses the strobes.
        @(posedge clk);
        #1 start_op(FUNC_DIV, 1'b1, 32'h55, 32'd0);
        @(posedge clk);
        #1 clear_req();
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall, hi_write, lo_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_done {stall,hi_w,lo_w}: got %b expected 000",
                     {stall, hi_write, lo_write});
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall, hi_write, lo_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_done_after {stall,hi_w,lo_w}: got %b expected 000",
                     {stall, hi_write, lo_write});
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        @(posedge clk);
        #1 start_op(FUNC_DIV, 1'b0, 32'h0000_FFFF, 32'd3);
        @(posedge clk);
        #1 clear_req();
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({stall, hi_write, lo_write, hi_write_data, lo_write_data} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div outputs: got stall=%b hw=%b lw=%b hi=%08h lo=%08h expected all 0",
                     stall, hi_write, lo_write, hi_write_data, lo_write_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (hi_write || lo_write || stall) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_div no_activity: got strobe/stall seen=%b expected 0", seen);
        end
        run_op("udiv_after_reset", FUNC_DIV, 1'b0, 32'd100, 32'd7, 34,
               32'h0000_0002, 32'h0000_000E);
    endtask

    initial begin
        clear_req();
        flush = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
